// File: rtl/sh7604_frt_irq_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : sh7604_frt_irq_ctl
//  Purpose  : FRT interrupt controller slice. Holds the FRT priority level
//             (IPRB[11:8]) and the FICV/FOCV/FOVV vectors. Arbitrates the four
//             FRT requests with fixed priority and runs a request/ack handshake
//             (IDLE -> PEND -> HOLD) toward the CPU.
//  Revision : 1.0 - initial release
// ============================================================================
module sh7604_frt_irq_ctl #(
    parameter logic [31:0] ABASE = 32'hFFFFFE60
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        ICI_IRQ,
    input  logic        OCIA_IRQ,
    input  logic        OCIB_IRQ,
    input  logic        OVI_IRQ,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic [31:0] IBUS_DO,
    output logic        IBUS_ACT,
    output logic        INT_REQ,
    output logic [3:0]  INT_LVL,
    output logic [6:0]  INT_VEC,
    input  logic        INT_ACK,
    output logic [1:0]  INT_SRC,
    output logic        ACK_PULSE
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_PEND = 2'd1;
    localparam logic [1:0] c_S_HOLD = 2'd2;

    // Register file (only implemented fields are stored)
    logic [3:0]  r_lvl;
    logic [6:0]  r_ficv;
    logic [6:0]  r_focv;
    logic [6:0]  r_fovv;

    // Handshake state and latched request
    logic [1:0]  r_state;
    logic        r_int_req;
    logic [3:0]  r_int_lvl;
    logic [6:0]  r_int_vec;
    logic [1:0]  r_int_src;
    logic [1:0]  r_hold_cnt;

    logic [1:0]  w_state_nxt;
    logic        w_req_nxt;
    logic [3:0]  w_lvl_nxt;
    logic [6:0]  w_vec_nxt;
    logic [1:0]  w_src_nxt;
    logic [1:0]  w_cnt_nxt;
    logic        w_ack;

    logic [31:0] w_off;
    logic        w_hit;
    logic        w_wr;
    logic [1:0]  w_sel;
    logic [31:0] w_do;
    logic [3:0]  w_src;
    logic        w_any;
    logic [1:0]  w_pick;
    logic [6:0]  w_pick_vec;
    logic        w_lat_hi;
    logic        w_unused;

    // Address offset from the window base; addresses below ABASE wrap to
    // large values and therefore miss.
    assign w_off = IBUS_A - ABASE;
    assign w_hit = (w_off <= 32'd9);
    assign w_sel = w_off[3:2];
    assign w_wr  = IBUS_REQ & IBUS_WE & w_hit & CE_R;

    // Source vector indexed by source id: 0=ICI, 1=OCIA, 2=OCIB, 3=OVI
    assign w_src    = {OVI_IRQ, OCIB_IRQ, OCIA_IRQ, ICI_IRQ};
    assign w_any    = |w_src;
    assign w_lat_hi = w_src[r_int_src];

    // Bus bits and lanes that map onto unimplemented register bits
    assign w_unused = &{1'b0, IBUS_DI[31], IBUS_DI[23:15], IBUS_DI[7], IBUS_BA[2]};

    // Fixed-priority pick and the vector that belongs to it
    always_comb begin
        w_pick     = 2'd3;
        w_pick_vec = r_fovv;
        if (ICI_IRQ) begin
            w_pick     = 2'd0;
            w_pick_vec = r_ficv;
        end else if (OCIA_IRQ) begin
            w_pick     = 2'd1;
            w_pick_vec = r_focv;
        end else if (OCIB_IRQ) begin
            w_pick     = 2'd2;
            w_pick_vec = r_focv;
        end
    end

    // Read mux: word-aligned view of the three registers inside the window
    always_comb begin
        w_do = 32'h0;
        if (w_hit) begin
            case (w_sel)
                2'd0:    w_do = {4'h0, r_lvl, 24'h0};
                2'd1:    w_do = {17'h0, r_ficv, 1'b0, r_focv};
                2'd2:    w_do = {1'b0, r_fovv, 24'h0};
                default: w_do = 32'h0;
            endcase
        end
    end

    // Register writes, byte-lane qualified
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lvl  <= 4'h0;
            r_ficv <= 7'h0;
            r_focv <= 7'h0;
            r_fovv <= 7'h0;
        end else if (w_wr) begin
            case (w_sel)
                2'd0: begin
                    if (IBUS_BA[3]) r_lvl <= IBUS_DI[27:24];
                end
                2'd1: begin
                    if (IBUS_BA[1]) r_ficv <= IBUS_DI[14:8];
                    if (IBUS_BA[0]) r_focv <= IBUS_DI[6:0];
                end
                2'd2: begin
                    if (IBUS_BA[3]) r_fovv <= IBUS_DI[30:24];
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and latched-request logic; PEND never re-arbitrates
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_int_req;
        w_lvl_nxt   = r_int_lvl;
        w_vec_nxt   = r_int_vec;
        w_src_nxt   = r_int_src;
        w_cnt_nxt   = r_hold_cnt;
        w_ack       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_any && (r_lvl != 4'h0)) begin
                    w_state_nxt = c_S_PEND;
                    w_req_nxt   = 1'b1;
                    w_lvl_nxt   = r_lvl;
                    w_vec_nxt   = w_pick_vec;
                    w_src_nxt   = w_pick;
                end
            end
            c_S_PEND: begin
                if (INT_ACK) begin
                    w_ack       = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = c_S_HOLD;
                end else if (!w_lat_hi || (r_lvl == 4'h0)) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_HOLD: begin
                if ((r_hold_cnt >= 2'd2) && !w_lat_hi) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = c_S_IDLE;
                end else if (r_hold_cnt != 2'd3) begin
                    w_cnt_nxt = r_hold_cnt + 2'd1;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State register; reset wins over clock enable
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_S_IDLE;
            r_int_req  <= 1'b0;
            r_int_lvl  <= 4'h0;
            r_int_vec  <= 7'h0;
            r_int_src  <= 2'd0;
            r_hold_cnt <= 2'd0;
        end else if (CE_R) begin
            r_state    <= w_state_nxt;
            r_int_req  <= w_req_nxt;
            r_int_lvl  <= w_lvl_nxt;
            r_int_vec  <= w_vec_nxt;
            r_int_src  <= w_src_nxt;
            r_hold_cnt <= w_cnt_nxt;
        end
    end

    assign IBUS_DO   = w_do;
    assign IBUS_ACT  = w_hit;
    assign INT_REQ   = r_int_req;
    assign INT_LVL   = r_int_lvl;
    assign INT_VEC   = r_int_vec;
    assign INT_SRC   = r_int_src;
    assign ACK_PULSE = w_ack & CE_R & ~RST;

endmodule
`default_nettype wire

// File: doc/sh7604_frt_irq_ctl.md
SH7604_FRT_IRQ_CTL -- requirements
Module: sh7604_frt_irq_ctl

Interface
REQ-001 SHALL have parameter ABASE, default 32'hFFFFFE60, meaning base address of the register window.
REQ-002 SHALL have ports: CLK  in  1  system clock.
REQ-003 SHALL have ports: RST  in  1  reset, synchronous, active-high, sampled on CLK regardless of CE_R.
REQ-004 SHALL have ports: CE_R  in  1  clock enable; all state advances only when CE_R=1.
REQ-005 SHALL have ports: ICI_IRQ, OCIA_IRQ, OCIB_IRQ, OVI_IRQ  in  1 each  level requests from the FRT (flag AND enable).
REQ-006 SHALL have ports: IBUS_A  in  32  address; IBUS_DI  in  32  write data; IBUS_BA  in  4  byte lanes, BA[3]=DI[31:24]; IBUS_WE  in  1; IBUS_REQ  in  1.
REQ-007 SHALL have ports: IBUS_DO  out  32  read data; IBUS_ACT  out  1  window hit.
REQ-008 SHALL have ports: INT_REQ  out  1; INT_LVL  out  4; INT_VEC  out  7; INT_ACK  in  1  CPU acceptance, one CE cycle.
REQ-009 SHALL have ports: INT_SRC  out  2  latched source (0=ICI,1=OCIA,2=OCIB,3=OVI); ACK_PULSE  out  1  one-cycle acceptance strobe to FRT.

Function
REQ-010 Registers: IPRB at ABASE+0 (bits 15:0 in DI[31:16]), FRT level IPRB[11:8]; VCRC at ABASE+6 (DI[15:0]), FICV=[14:8], FOCV=[6:0]; VCRD at ABASE+8 (DI[31:16]), FOVV=[14:8]; unimplemented bits read 0, writes ignored.
REQ-011 Writes SHALL occur when IBUS_REQ&IBUS_WE&window hit&CE_R, per byte lane enabled in IBUS_BA.
REQ-012 IBUS_ACT SHALL be 1 for IBUS_A in [ABASE, ABASE+9]; IBUS_DO SHALL be combinational register contents at hit, else 0.
REQ-013 Fixed priority ICI > OCIA > OCIB > OVI; vector ICI->FICV, OCIA/OCIB->FOCV, OVI->FOVV.
REQ-014 States: IDLE, PEND, HOLD; encoding free.
REQ-015 IDLE: if any source high and level!=0, latch highest source into INT_SRC, INT_VEC=its vector, INT_LVL=level, INT_REQ<=1, go PEND next cycle; level=0 masks all, stays IDLE.
REQ-016 PEND: INT_REQ=1; vector/level/source stable. INT_ACK=1 -> ACK_PULSE=1 for that cycle, INT_REQ<=0, go HOLD.
REQ-017 PEND withdraw: latched source low, or level written 0, with INT_ACK=0 -> INT_REQ<=0, go IDLE (no ACK_PULSE); INT_ACK wins if same cycle.
REQ-018 PEND SHALL NOT re-arbitrate: a higher source arriving during PEND waits until IDLE.
REQ-019 HOLD: 2-bit counter; exit to IDLE when counter>=2 CE cycles elapsed AND latched source low; no request issued in HOLD.
REQ-020 Vector/level register writes during PEND SHALL NOT change INT_VEC/INT_LVL (except REQ-017 level=0 withdraw).
REQ-021 INT_ACK in IDLE or HOLD SHALL be ignored (no pulse, no state change).
REQ-022 From IDLE, new request latency SHALL be 1 CE cycle from source high to INT_REQ=1.

Reset
REQ-023 RST=1 SHALL force IDLE, INT_REQ=0, INT_LVL=0, INT_VEC=0, INT_SRC=0, ACK_PULSE=0, IPRB/VCRC/VCRD=0, HOLD counter=0, in the same cycle, also mid-PEND/HOLD.
REQ-024 With RST=1, CE_R SHALL be ignored; register writes SHALL be ignored.

Verification
REQ-025 Write IPRB=16'h0500, VCRC=16'h4142, assert OCIB_IRQ -> next CE cycle INT_REQ=1, INT_LVL=5, INT_VEC=7'h42, INT_SRC=2.
REQ-026 ICI_IRQ and OVI_IRQ same cycle, FICV=7'h41, FOVV=7'h43 -> INT_VEC=7'h41; ACK, drop ICI after 2 cycles -> IDLE then INT_VEC=7'h43.
REQ-027 In PEND drop latched source, INT_ACK=0 -> INT_REQ=0 next cycle, ACK_PULSE never set.
REQ-028 IPRB[11:8]=0 with all sources high for 20 cycles -> INT_REQ stays 0.
REQ-029 INT_ACK while source stays high -> ACK_PULSE one cycle, HOLD persists until source low, INT_REQ=0 throughout.
REQ-030 RST=1 in PEND -> INT_REQ=0, INT_VEC=0, registers read 0 next read.
